multi_alarm_clock: RTL

- Parametrised successor to the single-alarm MM:SS clock/control pair.
- Parses UART command characters to set the running time and NUM_ALARMS independent alarms, each with its own arm/trigger state.
- Loads are staged and commit atomically on carriage return. The clock keeps running while a command is being entered.
- Sits between the UART receive path and the display/serial-status logic; time digits feed the seven-segment decoders.

---
 rtl/multi_alarm_clock.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multi_alarm_clock.sv
// MM:SS clock with NUM_ALARMS independent alarms, driven by UART commands.
// Time/alarm loads are staged and commit atomically on carriage return.
module multi_alarm_clock #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  oneSecStrb,
    input  logic                  bu_rx_data_rdy,
    input  logic [7:0]            bu_rx_data,
    output logic [15:0]           di_time,
    input  logic [IDX_W-1:0]      alarm_sel,
    output logic [15:0]           alarm_sel_value,
    output logic [NUM_ALARMS-1:0] alarm_armed,
    output logic [NUM_ALARMS-1:0] alarm_trig,
    output logic                  any_trig,
    output logic                  cmd_busy,
    output logic                  cmd_err
);

    typedef enum logic [3:0] {
        IDLE, T_MT, T_MO, T_ST, T_SO, T_CR,
        A_IDX, A_MT, A_MO, A_ST, A_SO, A_CR, ARM_IDX
    } state_t;

    localparam logic [7:0] IDX_LIM = 8'(48 + NUM_ALARMS);

    state_t      state_q, state_d;
    logic [15:0] stage_q, stage_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  tgt_idx;
    logic        ld_time, ld_alarm, arm_cmd, err_d, ok;
    logic        is_tens, is_ones, is_idx, is_cr;
    logic [15:0] alarm_q [NUM_ALARMS];
    logic [7:0]  rx;

    // BCD MM:SS increment with 59:59 -> 00:00 wrap
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        if (t[3:0] != 4'd9) begin
            t[3:0] = t[3:0] + 4'd1;
        end else begin
            t[3:0] = 4'd0;
            if (t[7:4] != 4'd5) begin
                t[7:4] = t[7:4] + 4'd1;
            end else begin
                t[7:4] = 4'd0;
                if (t[11:8] != 4'd9) begin
                    t[11:8] = t[11:8] + 4'd1;
                end else begin
                    t[11:8]  = 4'd0;
                    t[15:12] = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
                end
            end
        end
        return t;
    endfunction

    assign rx       = bu_rx_data;
    assign is_tens  = (rx >= 8'h30) && (rx <= 8'h35);
    assign is_ones  = (rx >= 8'h30) && (rx <= 8'h39);
    assign is_idx   = (rx >= 8'h30) && (rx < IDX_LIM);
    assign is_cr    = (rx == 8'h0D);
    assign any_trig = |alarm_trig;
    assign cmd_busy = (state_q != IDLE);

    // Parser next state; a rejected character undoes every staged effect
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        idx_d    = idx_q;
        tgt_idx  = idx_q;
        ld_time  = 1'b0;
        ld_alarm = 1'b0;
        arm_cmd  = 1'b0;
        err_d    = 1'b0;
        ok       = 1'b1;
        if (bu_rx_data_rdy) begin
            case (state_q)
                IDLE: begin
                    if (rx == 8'h6C)      state_d = T_MT;
                    else if (rx == 8'h61) state_d = A_IDX;
                    else if (rx == 8'h40) state_d = ARM_IDX;
                end
                T_MT: begin
                    ok = is_tens; stage_d[15:12] = rx[3:0]; state_d = T_MO;
                end
                T_MO: begin
                    ok = is_ones; stage_d[11:8] = rx[3:0]; state_d = T_ST;
                end
                T_ST: begin
                    ok = is_tens; stage_d[7:4] = rx[3:0]; state_d = T_SO;
                end
                T_SO: begin
                    ok = is_ones; stage_d[3:0] = rx[3:0]; state_d = T_CR;
                end
                T_CR: begin
                    ok = is_cr; ld_time = 1'b1; state_d = IDLE;
                end
                A_IDX: begin
                    ok = is_idx; idx_d = rx[3:0]; state_d = A_MT;
                end
                A_MT: begin
                    ok = is_tens; stage_d[15:12] = rx[3:0]; state_d = A_MO;
                end
                A_MO: begin
                    ok = is_ones; stage_d[11:8] = rx[3:0]; state_d = A_ST;
                end
                A_ST: begin
                    ok = is_tens; stage_d[7:4] = rx[3:0]; state_d = A_SO;
                end
                A_SO: begin
                    ok = is_ones; stage_d[3:0] = rx[3:0]; state_d = A_CR;
                end
                A_CR: begin
                    ok = is_cr; ld_alarm = 1'b1; state_d = IDLE;
                end
                ARM_IDX: begin
                    ok = is_idx; tgt_idx = rx[3:0]; arm_cmd = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (!ok) begin
                state_d  = IDLE;
                stage_d  = stage_q;
                idx_d    = idx_q;
                ld_time  = 1'b0;
                ld_alarm = 1'b0;
                arm_cmd  = 1'b0;
                err_d    = 1'b1;
            end
        end
    end

    // Parser state, staging registers and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            idx_q   <= '0;
            cmd_err <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            idx_q   <= idx_d;
            cmd_err <= err_d;
        end
    end

    // Running time; a committed load beats a coincident second strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             di_time <= '0;
        else if (ld_time)    di_time <= stage_q;
        else if (oneSecStrb) di_time <= bcd_inc(di_time);
    end

    // Alarm value registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_ALARMS; k++) alarm_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_ALARMS; k++)
                if (ld_alarm && tgt_idx == 4'(k)) alarm_q[k] <= stage_q;
        end
    end

    // Arm/trigger flags; an '@k' command takes priority over a match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_armed <= '0;
            alarm_trig  <= '0;
        end else begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (arm_cmd && tgt_idx == 4'(k)) begin
                    if (alarm_trig[k]) begin
                        alarm_trig[k]  <= 1'b0;
                        alarm_armed[k] <= 1'b0;
                    end else begin
                        alarm_armed[k] <= ~alarm_armed[k];
                    end
                end else if (alarm_armed[k] && !alarm_trig[k] &&
                             di_time == alarm_q[k]) begin
                    alarm_trig[k] <= 1'b1;
                end
            end
        end
    end

    // Readback mux; unpopulated indices read as zero
    always_comb begin
        alarm_sel_value = '0;
        for (int k = 0; k < NUM_ALARMS; k++)
            if (32'(alarm_sel) == k) alarm_sel_value = alarm_q[k];
    end

endmodule
